// File: rtl/if_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_defs (package)
// Description : Shared definitions for the IF-stage fetch unit: the NOP
//               instruction word, fetch-queue depth, FSM state encodings and
//               the {pc, inst} queue entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package if_defs;

   // addi x0, x0, 0 -- presented to ID whenever the queue is empty
   localparam logic [31:0] c_NOP_INST = 32'h0000_0013;

   // Fetch queue depth; the occupancy counter is 2 bits wide (0..2)
   localparam int unsigned c_FB_DEPTH = 2;

   typedef enum logic [0:0] {
      ST_FETCH   = 1'b0,   // normal fetching
      ST_DISCARD = 1'b1    // waiting out a stale access after a redirect
   } if_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fb_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : 2-entry synchronous FIFO of {pc, inst}. Entry 0 is always the
//               head, so the head is available straight from a register.
//               Flush has priority over push.
// Ports       : clk_i, rst_i        clock, synchronous active-high reset
//               push_i/push_data_i  write an entry (ignored when full and
//                                   not popping in the same cycle)
//               pop_i               remove the head (ignored when empty)
//               flush_i             empty the queue
//               head_o, count_o     head entry and occupancy (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
   import if_defs::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  fb_entry_t  push_data_i,
   input  logic       pop_i,
   input  logic       flush_i,
   output fb_entry_t  head_o,
   output logic [1:0] count_o
);

   fb_entry_t  entry_q [c_FB_DEPTH];
   fb_entry_t  entry_d [c_FB_DEPTH];
   logic [1:0] count_q, count_d;
   logic       do_pop, do_push;
   logic [1:0] slot;

   always_comb begin
      entry_d = entry_q;
      count_d = count_q;
      do_pop  = pop_i && (count_q != 2'd0);
      do_push = push_i && ((count_q < 2'd2) || do_pop);
      // Write position is the occupancy left after this cycle's pop
      slot    = count_q - {1'b0, do_pop};
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         if (do_pop) begin
            entry_d[0] = entry_q[1];
         end
         if (do_push) begin
            if (slot == 2'd0) begin
               entry_d[0] = push_data_i;
            end else begin
               entry_d[1] = push_data_i;
            end
         end
         count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         entry_q <= '{default: '0};
         count_q <= 2'd0;
      end else begin
         entry_q <= entry_d;
         count_q <= count_d;
      end
   end

   assign head_o  = entry_q[0];
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : IF-stage instruction fetch unit. Holds the fetch PC, issues
//               word reads over a busywait memory protocol and buffers
//               returned {pc, inst} pairs in a 2-entry queue whose head feeds
//               IF/ID. Honours ID stalls and EX redirects; an access made
//               stale by a redirect is completed and its data dropped.
// Ports       : CLK, RESET                 clock, sync active-high reset
//               stall                      ID cannot accept this cycle
//               branch_taken/branch_target redirect from EX
//               imem_addr/imem_read        fetch request
//               imem_readdata/imem_busywait memory response
//               inst/pc_out/inst_valid     queue head to IF/ID
//               fetch_count/imem_wait_count performance counters
//                                          (only with IF_PERF_CNT_EN)
// Config      : `define IF_PERF_CNT_EN adds the two performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
   import if_defs::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] imem_addr,
   output logic        imem_read,
   input  logic [31:0] imem_readdata,
   input  logic        imem_busywait,
   output logic [31:0] inst,
   output logic [31:0] pc_out,
   output logic        inst_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] imem_wait_count
`endif
);

   if_state_e   state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] redir_pc_q, redir_pc_d;
   logic        busy_q, busy_d;       // current access has seen busywait

   logic        pop, push, complete, read_req;
   logic [31:0] target;
   logic [1:0]  count;
   fb_entry_t   head;
   fb_entry_t   push_entry;

   assign target     = branch_target & 32'hFFFF_FFFC;
   assign push_entry = {fetch_pc_q, imem_readdata};

   fetch_buffer u_fetch_buffer (
      .clk_i       (CLK),
      .rst_i       (RESET),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (branch_taken),
      .head_o      (head),
      .count_o     (count)
   );

   assign inst_valid = (count != 2'd0);
   assign inst       = inst_valid ? head.inst : c_NOP_INST;
   assign pc_out     = inst_valid ? head.pc   : 32'h0000_0000;
   assign imem_addr  = fetch_pc_q;   // only changes on completion/redirect

   // Request generation. Once an access has started it must be kept up until
   // it completes, even if the queue would otherwise gate it off.
   always_comb begin
      pop = inst_valid && !stall && !branch_taken;
      if (state_q == ST_DISCARD) begin
         read_req = 1'b1;
      end else begin
         read_req = (count < 2'd2) || pop || busy_q;
      end
      imem_read = read_req && !RESET;
      complete  = imem_read && !imem_busywait;
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      redir_pc_d = redir_pc_q;
      busy_d     = busy_q;
      push       = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (branch_taken) begin
               busy_d = 1'b0;
               if (imem_read && imem_busywait) begin
                  // Access still pending: finish it, then jump
                  state_d    = ST_DISCARD;
                  redir_pc_d = target;
               end else begin
                  fetch_pc_d = target;
               end
            end else if (complete) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
               busy_d     = 1'b0;
            end else if (imem_read && imem_busywait) begin
               busy_d = 1'b1;
            end
         end
         ST_DISCARD: begin
            if (branch_taken) begin
               redir_pc_d = target;
            end
            if (complete) begin
               // Newest redirect wins if one lands in the completion cycle
               fetch_pc_d = branch_taken ? target : redir_pc_q;
               state_d    = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_FETCH;
         fetch_pc_q <= RESET_PC;
         redir_pc_q <= RESET_PC;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         redir_pc_q <= redir_pc_d;
         busy_q     <= busy_d;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] wait_cnt_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fetch_cnt_q <= 32'd0;
         wait_cnt_q  <= 32'd0;
      end else begin
         if (push) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (imem_read && imem_busywait) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
         end
      end
   end

   assign fetch_count     = fetch_cnt_q;
   assign imem_wait_count = wait_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit. Directed cycle table
//               for reset, streaming, stall, busywait and redirect cases,
//               followed by randomized traffic against a queue-based
//               reference model. Memory returns addr | 0x13.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic        imem_busywait = 1'b0;
   logic [31:0] imem_addr, imem_readdata, inst, pc_out;
   logic        imem_read, inst_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_count, imem_wait_count;
`endif

   always #5 CLK = ~CLK;

   assign imem_readdata = imem_addr | 32'h0000_0013;

   if_fetch_unit dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_read     (imem_read),
      .imem_readdata (imem_readdata),
      .imem_busywait (imem_busywait),
      .inst          (inst),
      .pc_out        (pc_out),
      .inst_valid    (inst_valid)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_count     (fetch_count),
      .imem_wait_count (imem_wait_count)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        rst, st, br;
      logic [31:0] tgt;
      logic        bw;
      logic        ev;
      logic [31:0] epc;
      logic        erd;
      logic [31:0] ea;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic st, input logic br,
                               input logic [31:0] tgt, input logic bw, input logic ev,
                               input logic [31:0] epc, input logic erd, input logic [31:0] ea);
      vec_t v;
      v.rst = rst; v.st = st; v.br = br; v.tgt = tgt; v.bw = bw;
      v.ev = ev; v.epc = epc; v.erd = erd; v.ea = ea;
      return v;
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_fpc, m_redir;
   bit          m_disc, m_started;
   logic [31:0] m_fcnt, m_wcnt;

   task automatic model_reset();
      mq.delete();
      m_fpc = 32'd0; m_redir = 32'd0;
      m_disc = 0; m_started = 0;
      m_fcnt = 32'd0; m_wcnt = 32'd0;
   endtask

   initial begin
      // row: rst st br tgt bw | valid pc read addr
      vecs.push_back(mk(1,0,0,32'h0,  0, 0,32'h0,  0,32'h0));
      vecs.push_back(mk(0,0,0,32'h0,  0, 0,32'h0,  1,32'h0));
      vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h0,  1,32'h4));
      vecs.push_back(mk(0,0,0,32'h0,  1, 1,32'h4,  1,32'h8));
      vecs.push_back(mk(0,0,0,32'h0,  1, 0,32'h0,  1,32'h8));
      vecs.push_back(mk(0,0,0,32'h0,  1, 0,32'h0,  1,32'h8));
      vecs.push_back(mk(0,0,0,32'h0,  0, 0,32'h0,  1,32'h8));
      vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h8,  1,32'hC));
      vecs.push_back(mk(0,0,1,32'h100,0, 1,32'hC,  1,32'h10));
      vecs.push_back(mk(0,0,0,32'h0,  0, 0,32'h0,  1,32'h100));
      vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h100,1,32'h104));
      vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h104,1,32'h108));
      vecs.push_back(mk(0,0,1,32'h10, 0, 1,32'h108,1,32'h10C));
      vecs.push_back(mk(0,0,0,32'h0,  1, 0,32'h0,  1,32'h10));
      vecs.push_back(mk(0,0,1,32'h203,1, 0,32'h0,  1,32'h10));
      vecs.push_back(mk(0,0,0,32'h0,  0, 0,32'h0,  1,32'h10));
      vecs.push_back(mk(0,0,0,32'h0,  0, 0,32'h0,  1,32'h200));
      vecs.push_back(mk(0,1,1,32'h300,0, 1,32'h200,1,32'h204));
      vecs.push_back(mk(0,0,0,32'h0,  0, 0,32'h0,  1,32'h300));
      vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h300,1,32'h304));
      vecs.push_back(mk(1,0,0,32'h0,  0, 1,32'h304,0,32'h0));
      vecs.push_back(mk(0,0,0,32'h0,  0, 0,32'h0,  1,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,  0, 1,32'h0,  1,32'h4));
      vecs.push_back(mk(0,1,0,32'h0,  0, 1,32'h0,  0,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,  0, 1,32'h0,  0,32'h0));
      vecs.push_back(mk(0,1,0,32'h0,  0, 1,32'h0,  0,32'h0));
      vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h0,  1,32'h8));
      vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h4,  1,32'hC));
      vecs.push_back(mk(0,0,0,32'h0,  0, 1,32'h8,  1,32'h10));

      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         RESET         = vecs[i].rst;
         stall         = vecs[i].st;
         branch_taken  = vecs[i].br;
         branch_target = vecs[i].tgt;
         imem_busywait = vecs[i].bw;
         #2;
         check($sformatf("row%0d inst_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].ev});
         check($sformatf("row%0d pc_out", i), pc_out, vecs[i].ev ? vecs[i].epc : 32'h0);
         check($sformatf("row%0d inst", i), inst,
               vecs[i].ev ? (vecs[i].epc | 32'h13) : 32'h0000_0013);
         check($sformatf("row%0d imem_read", i), {31'd0, imem_read}, {31'd0, vecs[i].erd});
         if (vecs[i].erd)
            check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].ea);
         @(posedge CLK);
         #1;
      end

      // ---------------- randomized phase ----------------
      RESET = 1'b1; stall = 1'b0; branch_taken = 1'b0; imem_busywait = 1'b0;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      model_reset();

      for (int c = 0; c < 600; c++) begin
         bit          s, b, w, e_valid, e_read, e_pop, e_cmp;
         logic [31:0] t;
         s = ($urandom_range(0, 9) < 4);
         b = ($urandom_range(0, 11) == 0);
         w = ($urandom_range(0, 9) < 3);
         t = $urandom();
         stall = s; branch_taken = b; branch_target = t; imem_busywait = w;
         #2;

         e_valid = (mq.size() > 0);
         e_pop   = e_valid && !s && !b;
         e_read  = m_disc ? 1'b1 : ((mq.size() < 2) || e_pop || m_started);

         check("rnd inst_valid", {31'd0, inst_valid}, {31'd0, e_valid});
         check("rnd pc_out", pc_out, e_valid ? mq[0].pc : 32'h0);
         check("rnd inst", inst, e_valid ? mq[0].inst : 32'h0000_0013);
         check("rnd imem_read", {31'd0, imem_read}, {31'd0, e_read});
         if (e_read) check("rnd imem_addr", imem_addr, m_fpc);
`ifdef IF_PERF_CNT_EN
         check("rnd fetch_count", fetch_count, m_fcnt);
         check("rnd imem_wait_count", imem_wait_count, m_wcnt);
`endif

         // advance the model by one clock
         e_cmp = e_read && !w;
         if (e_read && w) m_wcnt = m_wcnt + 32'd1;
         if (b) begin
            mq.delete();
            if (m_disc) begin
               m_redir = t & 32'hFFFF_FFFC;
               if (e_cmp) begin m_fpc = m_redir; m_disc = 0; end
            end else if (e_read && w) begin
               m_disc  = 1;
               m_redir = t & 32'hFFFF_FFFC;
            end else begin
               m_fpc = t & 32'hFFFF_FFFC;
            end
            m_started = 0;
         end else begin
            if (e_pop) void'(mq.pop_front());
            if (m_disc) begin
               if (e_cmp) begin m_fpc = m_redir; m_disc = 0; end
            end else if (e_cmp) begin
               ent_t en;
               en.pc = m_fpc; en.inst = m_fpc | 32'h13;
               mq.push_back(en);
               m_fpc     = m_fpc + 32'd4;
               m_started = 0;
               m_fcnt    = m_fcnt + 32'd1;
            end else if (e_read && w) begin
               m_started = 1;
            end
         end

         @(posedge CLK);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
